// File: rtl/eventually_window_monitor.sv
// eventually_window_monitor: multi-channel "signal eventually asserts" checker.
// After an accepted arm, each channel's asserted cycles are counted over a
// WINDOW-cycle window; at window end a one-cycle done pulse is issued with
// per-channel pass (hits >= MIN_HITS) / fail results. One-shot or continuous
// re-arm mode is latched when arm is accepted.
// Optional build macro: EVT_EARLY_EXIT_EN -- ends the window as soon as every
// channel (including the current sample) has reached MIN_HITS.
module eventually_window_monitor #(
  parameter  int NUM_CH   = 4,
  parameter  int WINDOW   = 20,
  parameter  int MIN_HITS = 1,
  localparam int HW       = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 cont_mode,
  input  logic [NUM_CH-1:0]    sig,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CH-1:0]    pass,
  output logic [NUM_CH-1:0]    fail,
  output logic [NUM_CH*HW-1:0] hit_cnt
);

  localparam logic [HW-1:0] LP_LAST = HW'(WINDOW - 1);
  localparam logic [HW-1:0] LP_MIN  = HW'(MIN_HITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [HW-1:0]      r_win;
  logic               r_mode;
  logic               r_done;
  logic [NUM_CH-1:0]  r_pass;
  logic [NUM_CH-1:0]  r_fail;
  logic [HW-1:0]      r_cnt     [NUM_CH];
  logic [HW-1:0]      w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  w_met;
  logic               w_last;
  logic               w_early;
  logic               w_clr_cnt;
  logic               w_clr_res;
  logic               w_cnt_en;
  logic               w_finish;
  logic               w_latch_mode;

  // Per-channel next count (current sample included) and threshold test.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_cnt_nxt[g] = r_cnt[g] + HW'(sig[g]);
    assign w_met[g]     = (w_cnt_nxt[g] >= LP_MIN);
    assign hit_cnt[g*HW +: HW] = r_cnt[g];

    // Hit counter: cleared on window start/abort, advanced on sampled edges.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt[g] <= '0;
      end else if (w_clr_cnt) begin
        r_cnt[g] <= '0;
      end else if (w_cnt_en) begin
        r_cnt[g] <= w_cnt_nxt[g];
      end
    end
  end

  assign w_last = (r_win == LP_LAST);

`ifdef EVT_EARLY_EXIT_EN
  assign w_early = &w_met;
`else
  assign w_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control; abort outranks completion and arm.
  always_comb begin
    w_next       = r_state;
    w_clr_cnt    = 1'b0;
    w_clr_res    = 1'b0;
    w_cnt_en     = 1'b0;
    w_finish     = 1'b0;
    w_latch_mode = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm && !abort) begin
          w_next       = S_ACTIVE;
          w_clr_cnt    = 1'b1;
          w_clr_res    = 1'b1;
          w_latch_mode = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          w_next    = S_IDLE;
          w_clr_cnt = 1'b1;
          w_clr_res = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
          if (w_last || w_early) begin
            w_next   = S_REPORT;
            w_finish = 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (abort) begin
          w_next    = S_IDLE;
          w_clr_cnt = 1'b1;
          w_clr_res = 1'b1;
        end else if (r_mode) begin
          w_next    = S_ACTIVE;
          w_clr_cnt = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Window sample counter; holds at its final value outside ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= '0;
    end else if (w_clr_cnt) begin
      r_win <= '0;
    end else if (w_cnt_en && !w_last) begin
      r_win <= r_win + HW'(1);
    end
  end

  // Mode latch: captured only when a window is started from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (w_latch_mode) begin
      r_mode <= cont_mode;
    end
  end

  // Results: written at window completion, cleared on arm/abort, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_pass <= '0;
      r_fail <= '0;
    end else begin
      r_done <= w_finish;
      if (w_clr_res) begin
        r_pass <= '0;
        r_fail <= '0;
      end else if (w_finish) begin
        r_pass <= w_met;
        r_fail <= ~w_met;
      end
    end
  end

  assign busy = (r_state == S_ACTIVE);
  assign done = r_done;
  assign pass = r_pass;
  assign fail = r_fail;

endmodule

// File: tb/tb_eventually_window_monitor.sv
// Randomized scoreboard bench for eventually_window_monitor.
module tb_eventually_window_monitor;

  localparam int NUM_CH   = 4;
  localparam int WINDOW   = 20;
  localparam int MIN_HITS = 3;
  localparam int HW       = $clog2(WINDOW + 1);

`ifdef EVT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [NUM_CH-1:0]    pass;
    logic [NUM_CH-1:0]    fail;
    logic [NUM_CH*HW-1:0] hit;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 arm;
  logic                 abort;
  logic                 cont_mode;
  logic [NUM_CH-1:0]    sig;
  logic                 busy;
  logic                 done;
  logic [NUM_CH-1:0]    pass;
  logic [NUM_CH-1:0]    fail;
  logic [NUM_CH*HW-1:0] hit_cnt;

  // WINDOW=1 boundary instance
  logic       w1_arm;
  logic       w1_abort;
  logic       w1_mode;
  logic [1:0] w1_sig;
  logic       w1_busy;
  logic       w1_done;
  logic [1:0] w1_pass;
  logic [1:0] w1_fail;
  logic [1:0] w1_hit;

  exp_t q[$];
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;

  eventually_window_monitor #(
    .NUM_CH  (NUM_CH),
    .WINDOW  (WINDOW),
    .MIN_HITS(MIN_HITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .abort    (abort),
    .cont_mode(cont_mode),
    .sig      (sig),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .hit_cnt  (hit_cnt)
  );

  eventually_window_monitor #(
    .NUM_CH  (2),
    .WINDOW  (1),
    .MIN_HITS(1)
  ) dut_w1 (
    .clk      (clk),
    .rst      (rst),
    .arm      (w1_arm),
    .abort    (w1_abort),
    .cont_mode(w1_mode),
    .sig      (w1_sig),
    .busy     (w1_busy),
    .done     (w1_done),
    .pass     (w1_pass),
    .fail     (w1_fail),
    .hit_cnt  (w1_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH-1:0] rsig(input int pct);
    logic [NUM_CH-1:0] s;
    for (int c = 0; c < NUM_CH; c++) s[c] = ($urandom_range(99) < pct);
    return s;
  endfunction

  function automatic logic [NUM_CH*HW-1:0] pack_cnt(input int cnt[NUM_CH]);
    logic [NUM_CH*HW-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v = cnt[c];
      r[c*HW +: HW] = v[HW-1:0];
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest expected window result.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pass_fail_disjoint", pass & fail, '0);
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          m_e = q.pop_front();
          chk("done_pass", pass, m_e.pass);
          chk("done_fail", fail, m_e.fail);
          chk("done_hit_cnt", hit_cnt, m_e.hit);
        end
      end
    end
  end

  // Drive one arm and up to nwin windows; abort_win/abort_at select an abort edge.
  task automatic run_windows(input bit mode, input int nwin, input int abort_win,
                             input int abort_at, input int pct);
    int   cnt [NUM_CH];
    bit   all_met;
    exp_t e;
    e.pass = '0; e.fail = '0; e.hit = '0;
    arm = 1'b1; cont_mode = mode; abort = 1'b0; sig = rsig(pct);
    cyc();
    arm = 1'b0; cont_mode = ~mode;
    chk("busy_after_arm", busy, 1);
    chk("hit_clear_on_arm", hit_cnt, '0);
    chk("pass_clear_on_arm", pass, '0);
    chk("fail_clear_on_arm", fail, '0);
    for (int w = 0; w < nwin; w++) begin
      foreach (cnt[c]) cnt[c] = 0;
      for (int i = 1; i <= WINDOW; i++) begin
        sig = rsig(pct); arm = 1'($urandom); cont_mode = 1'($urandom);
        if (w == abort_win && i == abort_at) begin
          abort = 1'b1;
          cyc();
          abort = 1'b0; arm = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_pass", pass, '0);
          chk("abort_fail", fail, '0);
          chk("abort_hit", hit_cnt, '0);
          return;
        end
        all_met = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          cnt[c] += int'(sig[c]);
          if (cnt[c] < MIN_HITS) all_met = 1'b0;
        end
        if (i == WINDOW || (EARLY && all_met)) begin
          for (int c = 0; c < NUM_CH; c++) e.pass[c] = (cnt[c] >= MIN_HITS);
          e.fail = ~e.pass;
          e.hit  = pack_cnt(cnt);
          q.push_back(e);
          cyc();
          break;
        end
        cyc();
        chk("busy_in_window", busy, 1);
        chk("hit_live", hit_cnt, pack_cnt(cnt));
      end
      chk("busy_in_report", busy, 0);
      sig = rsig(pct); arm = 1'($urandom); cont_mode = 1'($urandom);
      if (mode && w == nwin - 1) abort = 1'b1;
      cyc();
      abort = 1'b0; arm = 1'b0;
      chk("done_seen", q.size(), 0);
      if (!mode) begin
        chk("oneshot_idle", busy, 0);
        repeat (3) begin
          sig = rsig(50);
          cyc();
        end
        chk("pass_held", pass, e.pass);
        chk("fail_held", fail, e.fail);
        chk("hit_held", hit_cnt, e.hit);
        return;
      end else if (w == nwin - 1) begin
        chk("report_abort_busy", busy, 0);
        chk("report_abort_pass", pass, '0);
        chk("report_abort_fail", fail, '0);
        chk("report_abort_hit", hit_cnt, '0);
        return;
      end else begin
        chk("busy_rearm", busy, 1);
        chk("hit_clear_rearm", hit_cnt, '0);
        chk("pass_kept_rearm", pass, e.pass);
      end
    end
  endtask

  initial begin
    int aw;
    int aa;
    int nw;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; cont_mode = 1'b0; sig = '0;
    w1_arm = 1'b0; w1_abort = 1'b0; w1_mode = 1'b0; w1_sig = '0;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, '0);
    chk("rst_fail", fail, '0);
    chk("rst_hit", hit_cnt, '0);
    rst = 1'b0;
    cyc();

    // arm together with abort in IDLE is ignored
    arm = 1'b1; abort = 1'b1; sig = '1;
    cyc();
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", busy, 0);

    run_windows(1'b0, 1, -1, 0, 0);
    run_windows(1'b0, 1, -1, 0, 8);
    run_windows(1'b0, 1, -1, 0, 15);
    run_windows(1'b0, 1, -1, 0, 100);
    run_windows(1'b0, 1, 0, WINDOW, 50);
    run_windows(1'b0, 1, -1, 0, 20);
    run_windows(1'b1, 3, -1, 0, 100);
    run_windows(1'b1, 4, 2, 7, 100);

    // synchronous reset in the middle of a window
    arm = 1'b1; cont_mode = 1'b1; sig = '1;
    cyc();
    arm = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, '0);
    chk("midrst_fail", fail, '0);
    chk("midrst_hit", hit_cnt, '0);
    run_windows(1'b0, 1, -1, 0, 100);

    for (int k = 0; k < 16; k++) begin
      nw = $urandom_range(3, 1);
      if ($urandom_range(3) == 0) begin
        aw = $urandom_range(nw - 1, 0);
        aa = $urandom_range(WINDOW, 1);
      end else begin
        aw = -1;
        aa = 0;
      end
      run_windows(1'($urandom), nw, aw, aa, $urandom_range(40, 0));
    end

    // WINDOW=1: arm edge not counted, single sample on the next edge
    w1_arm = 1'b1; w1_sig = 2'b11;
    cyc();
    w1_arm = 1'b0; w1_sig = 2'b01;
    chk("w1_busy", w1_busy, 1);
    cyc();
    w1_sig = 2'b11;
    chk("w1_done", w1_done, 1);
    chk("w1_pass", w1_pass, 2'b01);
    chk("w1_fail", w1_fail, 2'b10);
    chk("w1_hit", w1_hit, 2'b01);
    cyc();
    chk("w1_done_once", w1_done, 0);
    chk("w1_hit_held", w1_hit, 2'b01);

    repeat (2) cyc();
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
